// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into big-endian 512-bit blocks and
// appends the 0x80 marker, zero fill and 64-bit message bit length.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_keep,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output logic         busy
);

  typedef enum logic [2:0] {FILL, PAD80, PADZ, PLEN, EMIT} state_t;

  state_t           state_q, state_d, ret_q, ret_d;
  logic [6:0]       idx_q, idx_d, idx_inc;
  logic [LEN_W-1:0] bitlen_q, bitlen_d;
  logic             first_q, first_d, final_q, final_d, busy_q, busy_d;
  logic             in_ready_q, in_ready_d, blk_valid_q, blk_valid_d;
  logic             blk_first_q, blk_first_d, blk_last_q, blk_last_d;
  logic [7:0]       buf_q [64];
  logic             wr_en;
  logic [5:0]       wr_addr, len_sel;
  logic [7:0]       wr_data;
  logic [63:0]      bitlen64;
  logic             accept;

  assign accept = in_valid && in_ready_q && (state_q == FILL);

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    idx_d    = idx_q;
    bitlen_d = bitlen_q;
    first_d  = first_q;
    final_d  = final_q;
    busy_d   = busy_q;
    wr_en    = 1'b0;
    wr_addr  = idx_q[5:0];
    wr_data  = 8'h00;
    idx_inc  = idx_q + 7'd1;
    bitlen64 = 64'(bitlen_q);
    len_sel  = 6'd63 - idx_q[5:0];

    case (state_q)
      FILL: begin
        if (accept) begin
          busy_d = 1'b1;
          if (in_keep) begin
            wr_en    = 1'b1;
            wr_data  = in_data;
            idx_d    = idx_inc;
            bitlen_d = bitlen_q + LEN_W'(8);
            if (idx_inc == 7'd64) begin
              state_d = EMIT;
              ret_d   = in_last ? PAD80 : FILL;
              final_d = 1'b0;
            end else if (in_last) begin
              state_d = PAD80;
            end
          end else if (in_last) begin
            state_d = PAD80;
          end
        end
      end
      PAD80, PADZ: begin
        wr_en   = 1'b1;
        wr_data = (state_q == PAD80) ? 8'h80 : 8'h00;
        idx_d   = idx_inc;
        if (idx_inc == 7'd56) begin
          state_d = PLEN;
        end else if (idx_inc == 7'd64) begin
          state_d = EMIT;
          ret_d   = PADZ;
          final_d = 1'b0;
        end else begin
          state_d = PADZ;
        end
      end
      PLEN: begin
        // Offsets 56..63 carry length bytes 7..0, most significant first.
        wr_en   = 1'b1;
        wr_data = 8'(bitlen64 >> {len_sel[2:0], 3'b000});
        idx_d   = idx_inc;
        if (idx_inc == 7'd64) begin
          state_d = EMIT;
          ret_d   = FILL;
          final_d = 1'b1;
        end
      end
      EMIT: begin
        if (blk_ready) begin
          idx_d   = 7'd0;
          first_d = 1'b0;
          state_d = ret_q;
          if (final_q) begin
            bitlen_d = '0;
            first_d  = 1'b1;
            busy_d   = 1'b0;
            final_d  = 1'b0;
          end
        end
      end
      default: state_d = FILL;
    endcase

    in_ready_d  = (state_d == FILL);
    blk_valid_d = (state_d == EMIT);
    blk_first_d = blk_first_q;
    blk_last_d  = blk_last_q;
    if (state_q != EMIT && state_d == EMIT) begin
      blk_first_d = first_q;
      blk_last_d  = final_d;
    end else if (state_d != EMIT) begin
      blk_first_d = 1'b0;
      blk_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      ret_q       <= FILL;
      idx_q       <= '0;
      bitlen_q    <= '0;
      first_q     <= 1'b1;
      final_q     <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      idx_q       <= idx_d;
      bitlen_q    <= bitlen_d;
      first_q     <= first_d;
      final_q     <= final_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      blk_valid_q <= blk_valid_d;
      blk_first_q <= blk_first_d;
      blk_last_q  <= blk_last_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) buf_q[i] <= 8'h00;
    end else if (wr_en) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < 64; gi++) begin : g_pack
    assign blk_data[511-8*gi -: 8] = buf_q[gi];
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;
  assign busy      = busy_q;

endmodule
